// File: rtl/wb_line_master.sv
// Wishbone B4 bus initiator: turns one cache-line request into an incrementing
// burst of BEATS beats and returns the assembled line with a one-cycle done pulse.
module wb_line_master #(
  parameter int OPTN_WB_DATA_WIDTH = 32,
  parameter int OPTN_WB_ADDR_WIDTH = 32,
  parameter int OPTN_LINE_SIZE     = 32
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              i_req_valid,
  input  logic                              i_req_we,
  input  logic [OPTN_WB_ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [OPTN_LINE_SIZE*8-1:0]       i_req_data,
  output logic                              o_req_ready,
  output logic                              o_done,
  output logic [OPTN_LINE_SIZE*8-1:0]       o_rdata,
  input  logic                              i_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]     i_wb_data,
  output logic                              o_wb_cyc,
  output logic                              o_wb_stb,
  output logic                              o_wb_we,
  output logic [2:0]                        o_wb_cti,
  output logic [1:0]                        o_wb_bte,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0]   o_wb_sel,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]     o_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0]     o_wb_data
);

  localparam int DW           = OPTN_WB_DATA_WIDTH;
  localparam int AW           = OPTN_WB_ADDR_WIDTH;
  localparam int WB_DATA_SIZE = OPTN_WB_DATA_WIDTH / 8;
  localparam int BEATS        = OPTN_LINE_SIZE / WB_DATA_SIZE;
  localparam int LINE_WIDTH   = OPTN_LINE_SIZE * 8;
  localparam int BW           = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSB          = $clog2(WB_DATA_SIZE);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW-1:0] LINE_MASK = ~AW'(OPTN_LINE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                  state, next_state;
  logic                    we_q;
  logic [AW-1:0]           base_q;
  logic [LINE_WIDTH-1:0]   wline_q;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic [BW-1:0]           beat;
  logic                    last_beat;
  logic                    in_burst;

  assign last_beat = (beat == LAST_BEAT);
  assign in_burst  = (state == BURST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_req_valid) next_state = BURST;
      BURST:   if (i_wb_ack && last_beat) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, beat counter and read-line assembly; reset also discards a partial line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      we_q    <= 1'b0;
      base_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
      beat    <= '0;
    end else if (state == IDLE && i_req_valid) begin
      we_q    <= i_req_we;
      base_q  <= i_req_addr & LINE_MASK;
      wline_q <= i_req_data;
      beat    <= '0;
    end else if (in_burst && i_wb_ack) begin
      if (!we_q) rdata_q[beat*DW +: DW] <= i_wb_data;
      if (!last_beat) beat <= beat + BW'(1);
    end
  end

  always_comb begin
    o_req_ready = (state == IDLE);
    o_done      = (state == DONE);
    o_rdata     = rdata_q;
    o_wb_cyc    = in_burst;
    o_wb_stb    = in_burst;
    o_wb_we     = in_burst && we_q;
    o_wb_bte    = 2'b00;
    o_wb_sel    = '0;
    o_wb_cti    = 3'b000;
    o_wb_addr   = '0;
    o_wb_data   = '0;
    if (in_burst) begin
      o_wb_sel  = '1;
      o_wb_cti  = last_beat ? 3'b111 : 3'b010;
      o_wb_addr = base_q + (AW'(beat) << LSB);
      o_wb_data = wline_q[beat*DW +: DW];
    end
  end

endmodule

// File: tb/tb_wb_line_master.sv
// Directed self-checking bench for wb_line_master: 8-beat reads/writes with
// wait states, back-to-back requests, reset mid-burst, and a single-beat line.
module tb_wb_line_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_rst;

  logic         req_valid, req_we;
  logic [31:0]  req_addr;
  logic [255:0] req_data;
  logic         req_ready, done;
  logic [255:0] rdata;
  logic         wb_ack;
  logic [31:0]  wb_rdata;
  logic         wb_cyc, wb_stb, wb_we;
  logic [2:0]   wb_cti;
  logic [1:0]   wb_bte;
  logic [3:0]   wb_sel;
  logic [31:0]  wb_addr, wb_wdata;

  logic         s_req_valid;
  logic [31:0]  s_req_addr, s_req_data;
  logic         s_req_ready, s_done;
  logic [31:0]  s_rdata;
  logic         s_wb_cyc, s_wb_stb, s_wb_we;
  logic [2:0]   s_wb_cti;
  logic [1:0]   s_wb_bte;
  logic [3:0]   s_wb_sel;
  logic [31:0]  s_wb_addr, s_wb_wdata;

  int           resp_waits = 0;
  int           wcnt = 0;
  logic         rsp_ack = 1'b0;
  logic         spur_ack = 1'b0;

  int           n_checks = 0;
  int           n_fail = 0;

  logic [255:0] exp_line;
  logic [255:0] wr_line;

  wb_line_master dut (
    .clk(clk), .n_rst(n_rst),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_data(req_data), .o_req_ready(req_ready), .o_done(done), .o_rdata(rdata),
    .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_cti(wb_cti),
    .o_wb_bte(wb_bte), .o_wb_sel(wb_sel), .o_wb_addr(wb_addr), .o_wb_data(wb_wdata)
  );

  wb_line_master #(.OPTN_LINE_SIZE(4)) dut_single (
    .clk(clk), .n_rst(n_rst),
    .i_req_valid(s_req_valid), .i_req_we(1'b0), .i_req_addr(s_req_addr),
    .i_req_data(s_req_data), .o_req_ready(s_req_ready), .o_done(s_done), .o_rdata(s_rdata),
    .i_wb_ack(s_wb_cyc & s_wb_stb), .i_wb_data(32'h1234_5678),
    .o_wb_cyc(s_wb_cyc), .o_wb_stb(s_wb_stb), .o_wb_we(s_wb_we), .o_wb_cti(s_wb_cti),
    .o_wb_bte(s_wb_bte), .o_wb_sel(s_wb_sel), .o_wb_addr(s_wb_addr), .o_wb_data(s_wb_wdata)
  );

  // Responder: acks each beat after resp_waits wait cycles; read data encodes the address.
  assign wb_ack   = rsp_ack | spur_ack;
  assign wb_rdata = 32'hC0DE_0000 ^ wb_addr;

  always @(negedge clk) begin
    if (wb_cyc && wb_stb) begin
      if (wcnt >= resp_waits) begin
        rsp_ack = 1'b1;
        wcnt    = 0;
      end else begin
        rsp_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      rsp_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    s_req_valid = 1'b0;
    s_req_addr  = '0;
    s_req_data  = '0;
    n_rst       = 1'b1;
    #1 n_rst    = 1'b0;
    #1;
    check_output("rst_ready", req_ready, 1);
    check_output("rst_done",  done, 0);
    check_output("rst_cyc",   wb_cyc, 0);
    check_output("rst_stb",   wb_stb, 0);
    check_output("rst_we",    wb_we, 0);
    check_output("rst_cti",   wb_cti, 0);
    check_output("rst_bte",   wb_bte, 0);
    check_output("rst_sel",   wb_sel, 0);
    check_output("rst_addr",  wb_addr, 0);
    check_output("rst_wdata", wb_wdata, 0);
    check_output("rst_rdata", rdata, 0);
    #1 n_rst = 1'b1;
    tick();

    // Spurious ack while idle must not start anything
    spur_ack = 1'b1;
    tick();
    tick();
    check_output("spur_idle_ready", req_ready, 1);
    check_output("spur_idle_cyc",   wb_cyc, 0);
    check_output("spur_idle_rdata", rdata, 0);
    spur_ack = 1'b0;

    // Read of line 0x1220, zero-wait responder
    resp_waits = 0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h0000_1234;
    req_data   = {8{32'hDEAD_BEEF}};
    tick();
    req_valid  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_output("rd_cyc",  wb_cyc, 1);
      check_output("rd_stb",  wb_stb, 1);
      check_output("rd_we",   wb_we, 0);
      check_output("rd_sel",  wb_sel, 4'hF);
      check_output("rd_bte",  wb_bte, 0);
      check_output("rd_addr", wb_addr, 32'h1220 + 4 * k);
      check_output("rd_cti",  wb_cti, (k < 7) ? 3'b010 : 3'b111);
      check_output("rd_done_early", done, 0);
      exp_line[k*32 +: 32] = 32'hC0DE_0000 ^ (32'h1220 + 4 * k);
      tick();
    end
    check_output("rd_done",      done, 1);
    check_output("rd_done_cyc",  wb_cyc, 0);
    check_output("rd_done_rdy",  req_ready, 0);
    check_output("rd_rdata",     rdata, exp_line);
    tick();
    check_output("rd_ready_back", req_ready, 1);
    check_output("rd_done_pulse", done, 0);
    check_output("rd_rdata_hold", rdata, exp_line);

    // Write of line 0x40 with two wait cycles per beat
    resp_waits = 2;
    for (int k = 0; k < 8; k++) wr_line[k*32 +: 32] = 32'hA0 + k;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h0000_0040;
    req_data   = wr_line;
    tick();
    req_valid  = 1'b0;
    req_data   = '0;
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 3; w++) begin
        check_output("wr_cyc",   wb_cyc, 1);
        check_output("wr_we",    wb_we, 1);
        check_output("wr_sel",   wb_sel, 4'hF);
        check_output("wr_addr",  wb_addr, 32'h40 + 4 * k);
        check_output("wr_wdata", wb_wdata, 32'hA0 + k);
        check_output("wr_cti",   wb_cti, (k < 7) ? 3'b010 : 3'b111);
        tick();
      end
    end
    check_output("wr_done",  done, 1);
    check_output("wr_rdata", rdata, exp_line);
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    check_output("wr_ready_back",  req_ready, 1);
    check_output("spur_done_cyc",  wb_cyc, 0);
    check_output("spur_done_rdat", rdata, exp_line);

    // Back-to-back: read 0x100, then write 0x200 with valid held high
    resp_waits = 0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h0000_0100;
    tick();
    req_we     = 1'b1;
    req_addr   = 32'h0000_0200;
    req_data   = wr_line;
    for (int k = 0; k < 8; k++) begin
      check_output("b2b_rd_we",   wb_we, 0);
      check_output("b2b_rd_addr", wb_addr, 32'h100 + 4 * k);
      check_output("b2b_rd_rdy",  req_ready, 0);
      exp_line[k*32 +: 32] = 32'hC0DE_0000 ^ (32'h100 + 4 * k);
      tick();
    end
    check_output("b2b_done",      done, 1);
    check_output("b2b_gap1_cyc",  wb_cyc, 0);
    check_output("b2b_rdata",     rdata, exp_line);
    tick();
    check_output("b2b_gap2_cyc",  wb_cyc, 0);
    check_output("b2b_ready",     req_ready, 1);
    tick();
    req_valid  = 1'b0;
    check_output("b2b_wr_cyc",  wb_cyc, 1);
    check_output("b2b_wr_we",   wb_we, 1);
    check_output("b2b_wr_addr", wb_addr, 32'h200);
    check_output("b2b_wr_data", wb_wdata, 32'hA0);
    for (int k = 0; k < 8; k++) tick();
    check_output("b2b_wr_done",  done, 1);
    check_output("b2b_wr_rdata", rdata, exp_line);
    tick();

    // Reset asserted during beat 3 of a read
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0300;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check_output("mid_beat3_addr", wb_addr, 32'h30C);
    n_rst = 1'b0;
    #1;
    check_output("mid_rst_cyc",   wb_cyc, 0);
    check_output("mid_rst_stb",   wb_stb, 0);
    check_output("mid_rst_done",  done, 0);
    check_output("mid_rst_rdata", rdata, 0);
    check_output("mid_rst_ready", req_ready, 1);
    #1 n_rst = 1'b1;
    tick();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0404;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_output("post_rst_addr", wb_addr, 32'h400 + 4 * k);
      exp_line[k*32 +: 32] = 32'hC0DE_0000 ^ (32'h400 + 4 * k);
      tick();
    end
    check_output("post_rst_done",  done, 1);
    check_output("post_rst_rdata", rdata, exp_line);
    tick();

    // Single-beat line (4-byte line)
    s_req_valid = 1'b1;
    s_req_addr  = 32'h0000_0057;
    tick();
    s_req_valid = 1'b0;
    check_output("one_cyc",   s_wb_cyc, 1);
    check_output("one_cti",   s_wb_cti, 3'b111);
    check_output("one_addr",  s_wb_addr, 32'h54);
    check_output("one_early", s_done, 0);
    tick();
    check_output("one_done",  s_done, 1);
    check_output("one_rdata", s_rdata, 32'h1234_5678);
    check_output("one_cyc_lo", s_wb_cyc, 0);
    tick();
    check_output("one_ready", s_req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
